snake_body_tracker: RTL and testbench

Parametrised snake-body engine for the FPGA snake game. It holds the segment coordinates of the snake in a circular buffer and accepts one movement step at a time, with an optional grow flag. For each step it reports the new head cell to draw and the old tail cell to erase, and it detects wall and self collisions. It sits between the game FSM, which issues steps on each tick, and the VGA plot path, which consumes the head and erase coordinates.

---
 rtl/snake_pkg.sv | 44 ++++
 rtl/snake_body_tracker_if.sv | 35 +++
 rtl/snake_seg_ram.sv | 33 +++
 rtl/snake_body_tracker.sv | 244 ++++++++++++++++++++++++
 tb/tb_snake_body_tracker.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/snake_pkg.sv
// Shared types and helpers for the snake body tracker.
//   dir_t      : step direction, 0 RIGHT, 1 DOWN, 2 LEFT, 3 UP
//   state_t    : tracker FSM states
//   REVERSE    : opposite direction
//   delta_x/y  : signed unit step of a coordinate for a direction
package snake_pkg;

  typedef enum logic [1:0] {
    DirRight = 2'd0,
    DirDown  = 2'd1,
    DirLeft  = 2'd2,
    DirUp    = 2'd3
  } dir_t;

  typedef enum logic [2:0] {
    StInit,
    StReady,
    StCheck,
    StCommit,
    StDead
  } state_t;

  // Opposite directions differ only in bit 1.
  function automatic dir_t REVERSE(input dir_t d);
    return dir_t'(d ^ 2'b10);
  endfunction

  function automatic int delta_x(input dir_t d);
    unique case (d)
      DirRight: return 1;
      DirLeft:  return -1;
      default:  return 0;
    endcase
  endfunction

  function automatic int delta_y(input dir_t d);
    unique case (d)
      DirDown: return 1;
      DirUp:   return -1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/snake_body_tracker_if.sv
// Step/plot bus between the game FSM (master), the tracker (slave) and the plot path.
//   step_valid/step_ready/step_dir/step_grow : step handshake from the game FSM
//   done, head_x/head_y, erase_valid, erase_x/erase_y, len, dead : tracker results
interface snake_body_tracker_if
  import snake_pkg::*;
#(
  parameter int unsigned XW = 8,
  parameter int unsigned YW = 7,
  parameter int unsigned LW = 7
) ();

  logic          step_valid;
  logic          step_ready;
  dir_t          step_dir;
  logic          step_grow;
  logic          done;
  logic [XW-1:0] head_x;
  logic [YW-1:0] head_y;
  logic          erase_valid;
  logic [XW-1:0] erase_x;
  logic [YW-1:0] erase_y;
  logic [LW-1:0] len;
  logic          dead;

  modport master (
    output step_valid, step_dir, step_grow,
    input  step_ready, done, head_x, head_y, erase_valid, erase_x, erase_y, len, dead
  );

  modport slave (
    input  step_valid, step_dir, step_grow,
    output step_ready, done, head_x, head_y, erase_valid, erase_x, erase_y, len, dead
  );

endinterface

// File: rtl/snake_seg_ram.sv
// Segment coordinate store: Depth x Width, one synchronous write port and two
// asynchronous read ports (scan pointer and tail pointer).
//   i_clk               : clock
//   i_we/i_waddr/i_wdata: write port
//   i_raddr_a/o_rdata_a : read port A (collision scan)
//   i_raddr_b/o_rdata_b : read port B (tail to erase)
module snake_seg_ram #(
  parameter int unsigned Depth = 64,
  parameter int unsigned Width = 15,
  parameter int unsigned AddrW = $clog2(Depth)
) (
  input  logic             i_clk,
  input  logic             i_we,
  input  logic [AddrW-1:0] i_waddr,
  input  logic [Width-1:0] i_wdata,
  input  logic [AddrW-1:0] i_raddr_a,
  output logic [Width-1:0] o_rdata_a,
  input  logic [AddrW-1:0] i_raddr_b,
  output logic [Width-1:0] o_rdata_b
);

  logic [Width-1:0] r_mem [Depth];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/snake_body_tracker.sv
// Snake body engine: keeps segment coordinates in a circular buffer, takes one
// movement step at a time (optionally growing), reports the new head and the
// vacated tail, and detects wall and self collisions.
//   CLOCK_50 : clock, rising edge
//   rst_n    : asynchronous active-low reset
//   bus      : snake_body_tracker_if.slave (step handshake and results)
// Build option: define SNAKE_WRAP_EN to wrap around the grid edges instead of
// dying at the wall.
module snake_body_tracker
  import snake_pkg::*;
#(
  parameter int unsigned GRID_W    = 160,
  parameter int unsigned GRID_H    = 120,
  parameter int unsigned MAX_LEN   = 64,
  parameter int unsigned START_LEN = 3,
  parameter int unsigned START_X   = 20,
  parameter int unsigned START_Y   = 60
) (
  input logic                 CLOCK_50,
  input logic                 rst_n,
  snake_body_tracker_if.slave bus
);

  localparam int unsigned XW  = $clog2(GRID_W);
  localparam int unsigned YW  = $clog2(GRID_H);
  localparam int unsigned LW  = $clog2(MAX_LEN + 1);
  localparam int unsigned AW  = $clog2(MAX_LEN);
  localparam int unsigned CW  = XW + YW;
  localparam int unsigned XW1 = XW + 1;
  localparam int unsigned YW1 = YW + 1;

  localparam logic [XW:0]    LimX     = XW1'(GRID_W);
  localparam logic [YW:0]    LimY     = YW1'(GRID_H);
  localparam logic [XW-1:0]  StartX   = XW'(START_X);
  localparam logic [YW-1:0]  StartY   = YW'(START_Y);
  localparam logic [LW-1:0]  MaxLen   = LW'(MAX_LEN);
  localparam logic [AW-1:0]  LastIdx  = AW'(MAX_LEN - 1);
  localparam logic [AW-1:0]  InitLast = AW'(START_LEN - 1);

  state_t        r_state;
  dir_t          r_dir;
  logic          r_ready;
  logic          r_done;
  logic          r_dead;
  logic          r_erase_valid;
  logic [XW-1:0] r_erase_x;
  logic [YW-1:0] r_erase_y;
  logic [XW-1:0] r_head_x;
  logic [YW-1:0] r_head_y;
  logic [LW-1:0] r_len;
  logic [AW-1:0] r_head_ptr;
  logic [AW-1:0] r_tail_ptr;
  logic [AW-1:0] r_scan_ptr;
  logic [AW-1:0] r_init_cnt;
  logic [LW-1:0] r_cnt;
  logic          r_hit;
  logic          r_grow;
  logic [XW-1:0] r_new_x;
  logic [YW-1:0] r_new_y;

  dir_t          w_dir_eff;
  logic [XW:0]   w_nx;
  logic [YW:0]   w_ny;
  logic          w_out_x;
  logic          w_out_y;
  logic          w_wall;
  logic [XW-1:0] w_fit_x;
  logic [YW-1:0] w_fit_y;
  logic          w_grow;
  logic [LW-1:0] w_count;
  logic [AW-1:0] w_head_dec;
  logic [AW-1:0] w_tail_dec;
  logic [AW-1:0] w_scan_inc;
  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [CW-1:0] w_wdata;
  logic [CW-1:0] w_rd_scan;
  logic [CW-1:0] w_rd_tail;

  // Next head for the requested step, evaluated in the accept cycle.
  always_comb begin
    w_dir_eff = (bus.step_dir == REVERSE(r_dir)) ? r_dir : bus.step_dir;
    w_nx      = {1'b0, r_head_x} + XW1'(delta_x(w_dir_eff));
    w_ny      = {1'b0, r_head_y} + YW1'(delta_y(w_dir_eff));
    // A step below zero shows up as a large unsigned value, so one compare
    // catches both edges.
    w_out_x   = (w_nx >= LimX);
    w_out_y   = (w_ny >= LimY);
`ifdef SNAKE_WRAP_EN
    w_wall    = 1'b0;
    if (w_out_x) begin
      w_fit_x = (w_dir_eff == DirLeft) ? XW'(GRID_W - 1) : '0;
    end else begin
      w_fit_x = w_nx[XW-1:0];
    end
    if (w_out_y) begin
      w_fit_y = (w_dir_eff == DirUp) ? YW'(GRID_H - 1) : '0;
    end else begin
      w_fit_y = w_ny[YW-1:0];
    end
`else
    w_wall    = w_out_x | w_out_y;
    w_fit_x   = w_nx[XW-1:0];
    w_fit_y   = w_ny[YW-1:0];
`endif
    w_grow    = bus.step_grow && (r_len < MaxLen);
  end

  // Pointer arithmetic modulo MAX_LEN; MAX_LEN need not be a power of two.
  always_comb begin
    w_head_dec = (r_head_ptr == '0) ? LastIdx : r_head_ptr - AW'(1);
    w_tail_dec = (r_tail_ptr == '0) ? LastIdx : r_tail_ptr - AW'(1);
    w_scan_inc = (r_scan_ptr == LastIdx) ? '0 : r_scan_ptr + AW'(1);
    // The tail is left out of the scan on a plain move since it vacates its cell.
    w_count    = r_grow ? r_len : r_len - LW'(1);
  end

  // Single write port shared by initialisation and commit.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = r_init_cnt;
    w_wdata = {StartX - XW'(r_init_cnt), StartY};
    if (r_state == StInit) begin
      w_we = 1'b1;
    end else if (r_state == StCommit) begin
      w_we    = 1'b1;
      w_waddr = w_head_dec;
      w_wdata = {r_new_x, r_new_y};
    end
  end

  snake_seg_ram #(
    .Depth (MAX_LEN),
    .Width (CW)
  ) u_ram (
    .i_clk     (CLOCK_50),
    .i_we      (w_we),
    .i_waddr   (w_waddr),
    .i_wdata   (w_wdata),
    .i_raddr_a (r_scan_ptr),
    .o_rdata_a (w_rd_scan),
    .i_raddr_b (r_tail_ptr),
    .o_rdata_b (w_rd_tail)
  );

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StInit;
      r_dir         <= DirRight;
      r_ready       <= 1'b0;
      r_done        <= 1'b0;
      r_dead        <= 1'b0;
      r_erase_valid <= 1'b0;
      r_erase_x     <= '0;
      r_erase_y     <= '0;
      r_head_x      <= StartX;
      r_head_y      <= StartY;
      r_len         <= LW'(START_LEN);
      r_head_ptr    <= '0;
      r_tail_ptr    <= InitLast;
      r_scan_ptr    <= '0;
      r_init_cnt    <= '0;
      r_cnt         <= '0;
      r_hit         <= 1'b0;
      r_grow        <= 1'b0;
      r_new_x       <= '0;
      r_new_y       <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StInit: begin
          if (r_init_cnt == InitLast) begin
            r_init_cnt <= '0;
            r_ready    <= 1'b1;
            r_state    <= StReady;
          end else begin
            r_init_cnt <= r_init_cnt + AW'(1);
          end
        end
        StReady: begin
          if (bus.step_valid) begin
            r_ready    <= 1'b0;
            r_dir      <= w_dir_eff;
            r_new_x    <= w_fit_x;
            r_new_y    <= w_fit_y;
            r_grow     <= w_grow;
            r_scan_ptr <= r_head_ptr;
            r_cnt      <= '0;
            r_hit      <= 1'b0;
            r_state    <= w_wall ? StDead : StCheck;
          end
        end
        StCheck: begin
          // One segment per cycle; the verdict is taken once all are seen.
          if (r_cnt != w_count) begin
            r_hit      <= r_hit | (w_rd_scan == {r_new_x, r_new_y});
            r_scan_ptr <= w_scan_inc;
            r_cnt      <= r_cnt + LW'(1);
          end else begin
            r_state <= r_hit ? StDead : StCommit;
          end
        end
        StCommit: begin
          r_head_ptr <= w_head_dec;
          r_head_x   <= r_new_x;
          r_head_y   <= r_new_y;
          if (r_grow) begin
            r_len         <= r_len + LW'(1);
            r_erase_valid <= 1'b0;
          end else begin
            // Tail slot is read before the commit write can land on it.
            r_tail_ptr    <= w_tail_dec;
            r_erase_x     <= w_rd_tail[CW-1:YW];
            r_erase_y     <= w_rd_tail[YW-1:0];
            r_erase_valid <= 1'b1;
          end
          r_done  <= 1'b1;
          r_ready <= 1'b1;
          r_state <= StReady;
        end
        StDead: begin
          r_ready <= 1'b0;
          if (!r_dead) begin
            r_dead        <= 1'b1;
            r_done        <= 1'b1;
            r_erase_valid <= 1'b0;
          end
        end
        default: r_state <= StInit;
      endcase
    end
  end

  assign bus.step_ready  = r_ready;
  assign bus.done        = r_done;
  assign bus.head_x      = r_head_x;
  assign bus.head_y      = r_head_y;
  assign bus.erase_valid = r_erase_valid;
  assign bus.erase_x     = r_erase_x;
  assign bus.erase_y     = r_erase_y;
  assign bus.len         = r_len;
  assign bus.dead        = r_dead;

endmodule

// File: tb/tb_snake_body_tracker.sv
// Randomised scoreboard bench for snake_body_tracker on a 16x12 grid.
module tb_snake_body_tracker;
  import snake_pkg::*;

  localparam int GW = 16;
  localparam int GH = 12;
  localparam int ML = 8;
  localparam int SL = 3;
  localparam int SX = 5;
  localparam int SY = 5;
  localparam int XW = $clog2(GW);
  localparam int YW = $clog2(GH);
  localparam int LW = $clog2(ML + 1);

  typedef struct {
    int hx, hy, len, ev, ex, ey, dead, lat, acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference body, head first.
  int mx[$];
  int my[$];
  int mdir;
  int mdead;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snake_body_tracker_if #(.XW(XW), .YW(YW), .LW(LW)) bus ();

  snake_body_tracker #(
    .GRID_W    (GW),
    .GRID_H    (GH),
    .MAX_LEN   (ML),
    .START_LEN (SL),
    .START_X   (SX),
    .START_Y   (SY)
  ) dut (
    .CLOCK_50 (clk),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event (cycle %0d)", name, cyc);
  endtask

  function automatic void model_reset();
    mx.delete();
    my.delete();
    for (int i = 0; i < SL; i++) begin
      mx.push_back(SX - i);
      my.push_back(SY);
    end
    mdir  = 0;
    mdead = 0;
  endfunction

  function automatic exp_t model_step(input int dir_in, input bit g);
    exp_t e = '{default: 0};
    int   d = dir_in;
    int   nx, ny, cnt, sz;
    bit   grow, hit;
    sz = mx.size();
    if (d == (mdir + 2) % 4) d = mdir;
    nx = mx[0] + ((d == 0) ? 1 : 0) - ((d == 2) ? 1 : 0);
    ny = my[0] + ((d == 1) ? 1 : 0) - ((d == 3) ? 1 : 0);
    grow = g && (sz < ML);
    e.hx = mx[0];
    e.hy = my[0];
    e.len = sz;
`ifdef SNAKE_WRAP_EN
    nx = (nx + GW) % GW;
    ny = (ny + GH) % GH;
`else
    if (nx < 0 || nx >= GW || ny < 0 || ny >= GH) begin
      mdead = 1;
      e.dead = 1;
      e.lat = 1;
      return e;
    end
`endif
    cnt = grow ? sz : sz - 1;
    hit = 0;
    for (int i = 0; i < cnt; i++) if (mx[i] == nx && my[i] == ny) hit = 1;
    if (hit) begin
      mdead = 1;
      e.dead = 1;
      e.lat = -1;
      return e;
    end
    e.lat = grow ? sz + 2 : sz + 1;
    if (!grow) begin
      e.ev = 1;
      e.ex = mx[sz-1];
      e.ey = my[sz-1];
      void'(mx.pop_back());
      void'(my.pop_back());
    end
    mx.push_front(nx);
    my.push_front(ny);
    mdir = d;
    e.hx = nx;
    e.hy = ny;
    e.len = mx.size();
    return e;
  endfunction

  // Monitor: every done pulse is matched against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        e = sb.pop_front();
        check("head_x", int'(bus.head_x), e.hx);
        check("head_y", int'(bus.head_y), e.hy);
        check("len", int'(bus.len), e.len);
        check("dead", int'(bus.dead), e.dead);
        check("erase_valid", int'(bus.erase_valid), e.ev);
        if (e.ev != 0) begin
          check("erase_x", int'(bus.erase_x), e.ex);
          check("erase_y", int'(bus.erase_y), e.ey);
        end
        if (e.lat >= 0) check("latency", cyc - e.acc, e.lat);
      end
    end
  end

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.step_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic do_reset();
    int n;
    bus.step_valid = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    if (n >= 40) fail_now("ready_after_reset");
  endtask

  task automatic do_step(input int d, input bit g);
    int   w;
    exp_t e;
    wait_ready(w);
    if (w >= 40) begin
      fail_now("step_ready");
      return;
    end
    bus.step_valid = 1'b1;
    bus.step_dir   = dir_t'(d);
    bus.step_grow  = g;
    e = model_step(d, g);
    e.acc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    bus.step_valid = 1'b0;
    w = 0;
    while (sb.size() != 0 && w < 40) begin
      @(negedge clk);
      w++;
    end
    if (sb.size() != 0) begin
      fail_now("done_pulse");
      sb.delete();
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got hang expected finish");
    $fatal(1);
  end

  initial begin : stim
    int n;
    bus.step_valid = 1'b0;
    bus.step_dir   = DirRight;
    bus.step_grow  = 1'b0;
    model_reset();

    // Reset state and ready latency.
    @(negedge clk);
    @(negedge clk);
    check("rst_ready", int'(bus.step_ready), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_erase_valid", int'(bus.erase_valid), 0);
    check("rst_dead", int'(bus.dead), 0);
    check("rst_head_x", int'(bus.head_x), SX);
    check("rst_head_y", int'(bus.head_y), SY);
    check("rst_len", int'(bus.len), SL);
    check("rst_erase_x", int'(bus.erase_x), 0);
    check("rst_erase_y", int'(bus.erase_y), 0);
    rst_n = 1'b1;
    wait_ready(n);
    check("ready_latency", n, SL);

    // Plain move, reversal, growth to saturation, then the right wall.
    do_step(0, 1'b0);
    do_step(2, 1'b0);
    for (int i = 0; i < 6; i++) do_step(0, 1'b1);
    for (int i = 0; i < 3 && mdead == 0; i++) do_step(0, 1'b0);
    if (mdead == 0) do_step(0, 1'b0);

    // Self collision at length 5, then steps must be ignored.
    do_reset();
    do_step(0, 1'b1);
    do_step(0, 1'b1);
    do_step(3, 1'b0);
    do_step(2, 1'b0);
    do_step(1, 1'b0);
    for (int i = 0; i < 8; i++) begin
      bus.step_valid = 1'b1;
      bus.step_dir   = dir_t'($urandom_range(0, 3));
      @(negedge clk);
    end
    bus.step_valid = 1'b0;
    check("dead_sticky", int'(bus.dead), 1);
    check("dead_ready", int'(bus.step_ready), 0);
    check("dead_head_x", int'(bus.head_x), mx[0]);
    check("dead_head_y", int'(bus.head_y), my[0]);

    // Reset in the middle of the collision scan.
    do_reset();
    do_step(0, 1'b0);
    bus.step_valid = 1'b1;
    bus.step_dir   = DirDown;
    bus.step_grow  = 1'b0;
    @(negedge clk);
    bus.step_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    model_reset();
    #1;
    check("midrst_state", int'(dut.r_state), int'(StInit));
    check("midrst_head_x", int'(bus.head_x), SX);
    check("midrst_len", int'(bus.len), SL);
    @(negedge clk);
    rst_n = 1'b1;
    wait_ready(n);
    check("midrst_ready_latency", n, SL);
    do_step(0, 1'b0);
    do_step(1, 1'b0);

    // Random walks.
    for (int run = 0; run < 6; run++) begin
      do_reset();
      for (int k = 0; k < 40 && mdead == 0; k++) begin
        do_step(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0));
      end
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
